// File: rtl/core_state_sequencer.sv
// Instruction-cycle control FSM: one-hot state strobes, fetch/execute/stall handshakes, retire and halt status.
// Optional perf counters (cycle_count, instret_count) are built only when SEQ_PERF_COUNT_EN is defined.
module core_state_sequencer #(
   parameter int COUNT_WIDTH    = 32,
   parameter bit START_ON_RESET = 1'b0
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   start,
   output logic                   imem_req,
   input  logic                   imem_rvalid,
   input  logic                   exec_done,
   input  logic                   stall,
   input  logic                   halt_req,
   output logic                   fetch_RequestState,
   output logic                   fetch_ReceiveState,
   output logic                   decodeState,
   output logic                   setupState,
   output logic                   executeState,
   output logic                   writebackState,
   output logic                   retire,
   output logic                   halted,
   output logic [COUNT_WIDTH-1:0] cycle_count,
   output logic [COUNT_WIDTH-1:0] instret_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH_REQ,
      S_FETCH_RECV,
      S_DECODE,
      S_SETUP,
      S_EXECUTE,
      S_WRITEBACK,
      S_HALTED
   } state_e;

   state_e state_q, state_d;
   logic   retire_q;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         retire_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         retire_q <= (state_q == S_WRITEBACK);
      end
   end

   always_comb begin
      // NOTE: default to holding the current state so no path leaves state_d unassigned (no latch).
      state_d = state_q;
      unique case (state_q)
         S_IDLE:       if (start || START_ON_RESET) state_d = S_FETCH_REQ;
         S_FETCH_REQ:  if (imem_rvalid) state_d = S_FETCH_RECV;
         S_FETCH_RECV: state_d = S_DECODE;
         S_DECODE:     state_d = S_SETUP;
         S_SETUP:      if (!stall) state_d = S_EXECUTE;
         S_EXECUTE:    if (exec_done) state_d = S_WRITEBACK;
         S_WRITEBACK:  state_d = halt_req ? S_HALTED : S_FETCH_REQ;
         S_HALTED:     if (start) state_d = S_FETCH_REQ;
         default:      state_d = S_IDLE;
      endcase
   end

   always_comb begin
      fetch_RequestState = (state_q == S_FETCH_REQ);
      fetch_ReceiveState = (state_q == S_FETCH_RECV);
      decodeState        = (state_q == S_DECODE);
      setupState         = (state_q == S_SETUP);
      executeState       = (state_q == S_EXECUTE);
      writebackState     = (state_q == S_WRITEBACK);
      halted             = (state_q == S_HALTED);
      imem_req           = fetch_RequestState;
      retire             = retire_q;
   end

`ifdef SEQ_PERF_COUNT_EN
   logic [COUNT_WIDTH-1:0] cycle_q, instret_q;
   logic                   active;

   assign active = (state_q != S_IDLE) && (state_q != S_HALTED);

   // Both counters wrap naturally and clear only on reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cycle_q   <= '0;
         instret_q <= '0;
      end else begin
         if (active)   cycle_q   <= cycle_q + 1'b1;
         if (retire_q) instret_q <= instret_q + 1'b1;
      end
   end

   assign cycle_count   = cycle_q;
   assign instret_count = instret_q;
`else
   assign cycle_count   = '0;
   assign instret_count = '0;
`endif

endmodule

// File: tb/tb_core_state_sequencer.sv
// Directed bench for core_state_sequencer: expected output vectors are queued as stimulus is applied
// and popped against the DUT one cycle later; perf counters are checked against a bench-side model.
module tb_core_state_sequencer;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          start, imem_rvalid, exec_done, stall, halt_req;
   logic          imem_req, retire, halted;
   logic          fr, fv, dc, su, ex, wb;
   logic [CW-1:0] cycle_count, instret_count;

   core_state_sequencer #(.COUNT_WIDTH(CW), .START_ON_RESET(1'b0)) dut (
      .clk                (clk),
      .reset_n            (reset_n),
      .start              (start),
      .imem_req           (imem_req),
      .imem_rvalid        (imem_rvalid),
      .exec_done          (exec_done),
      .stall              (stall),
      .halt_req           (halt_req),
      .fetch_RequestState (fr),
      .fetch_ReceiveState (fv),
      .decodeState        (dc),
      .setupState         (su),
      .executeState       (ex),
      .writebackState     (wb),
      .retire             (retire),
      .halted             (halted),
      .cycle_count        (cycle_count),
      .instret_count      (instret_count)
   );

   always #5 clk = ~clk;

   // Vector layout: {FR, FV, D, S, E, W, imem_req, retire, halted}
   localparam logic [8:0] V_IDLE = 9'b000000_000;
   localparam logic [8:0] V_FR   = 9'b100000_100;
   localparam logic [8:0] V_FR_R = 9'b100000_110;
   localparam logic [8:0] V_FV   = 9'b010000_000;
   localparam logic [8:0] V_D    = 9'b001000_000;
   localparam logic [8:0] V_S    = 9'b000100_000;
   localparam logic [8:0] V_E    = 9'b000010_000;
   localparam logic [8:0] V_W    = 9'b000001_000;
   localparam logic [8:0] V_H    = 9'b000000_001;
   localparam logic [8:0] V_H_R  = 9'b000000_011;

   typedef struct {
      string      tag;
      logic [8:0] v;
   } exp_t;

   exp_t       exp_q[$];
   int         n_cmp = 0;
   int         n_err = 0;
   logic [8:0] last_exp = '0;
   int         model_cyc = 0;
   int         model_ins = 0;

   function automatic logic [8:0] observed();
      return {fr, fv, dc, su, ex, wb, imem_req, retire, halted};
   endfunction

   task automatic compare_head();
      exp_t e;
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_err++;
         $error("FAIL scoreboard_empty: observed %b required an expected entry", observed());
      end else begin
         e = exp_q.pop_front();
         n_cmp++;
         assert (observed() === e.v)
         else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", e.tag, observed(), e.v);
         end
      end
   endtask

   task automatic now(input string tag, input logic [8:0] v);
      exp_q.push_back('{tag, v});
      compare_head();
   endtask

   // Queue the expectation, advance one clock, update the counter model, then check.
   task automatic step(input string tag, input logic [8:0] v);
      exp_q.push_back('{tag, v});
      @(posedge clk);
      #1;
      if (|last_exp[8:3]) model_cyc++;
      if (last_exp[1])    model_ins++;
      last_exp = v;
      compare_head();
   endtask

   task automatic check_counters(input string tag);
      logic [CW-1:0] exp_c, exp_i;
`ifdef SEQ_PERF_COUNT_EN
      exp_c = CW'(model_cyc);
      exp_i = CW'(model_ins);
`else
      exp_c = '0;
      exp_i = '0;
`endif
      n_cmp++;
      assert (cycle_count === exp_c)
      else begin
         n_err++;
         $error("FAIL %s_cycle: observed %0d expected %0d", tag, cycle_count, exp_c);
      end
      n_cmp++;
      assert (instret_count === exp_i)
      else begin
         n_err++;
         $error("FAIL %s_instret: observed %0d expected %0d", tag, instret_count, exp_i);
      end
   endtask

   task automatic clear_model();
      last_exp  = '0;
      model_cyc = 0;
      model_ins = 0;
   endtask

   // Requires FR currently observed with imem_rvalid=1, exec_done=1, stall=0.
   task automatic run_fast();
      step("fast_fv", V_FV);
      step("fast_d",  V_D);
      step("fast_s",  V_S);
      step("fast_e",  V_E);
      step("fast_w",  V_W);
      step("fast_fr_retire", V_FR_R);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n     = 1'b0;
      start       = 1'b0;
      imem_rvalid = 1'b0;
      exec_done   = 1'b0;
      stall       = 1'b0;
      halt_req    = 1'b0;
      #12;
      now("reset", V_IDLE);
      clear_model();
      check_counters("reset");
      @(negedge clk);
      reset_n = 1'b1;

      // 1: idle without start, then start
      for (int i = 0; i < 5; i++) step("idle_no_start", V_IDLE);
      start = 1'b1;
      step("start_fetch", V_FR);
      start = 1'b0;

      // 2: back-to-back minimum-latency instructions
      imem_rvalid = 1'b1;
      exec_done   = 1'b1;
      stall       = 1'b0;
      repeat (3) run_fast();
      check_counters("after_fast");

      // 3: rvalid late, stall in SETUP, slow execute
      imem_rvalid = 1'b0;
      exec_done   = 1'b0;
      stall       = 1'b1;
      step("fr_wait1", V_FR);
      step("fr_wait2", V_FR);
      step("fr_wait3", V_FR);
      imem_rvalid = 1'b1;
      step("slow_fv", V_FV);
      step("slow_d",  V_D);
      step("stall_s1", V_S);
      step("stall_s2", V_S);
      step("stall_s3", V_S);
      stall = 1'b0;
      step("exec_e1", V_E);
      step("exec_e2", V_E);
      step("exec_e3", V_E);
      step("exec_e4", V_E);
      exec_done = 1'b1;
      step("slow_w", V_W);
      step("slow_retire", V_FR_R);

      // 4: halt in WRITEBACK wins over start, then restart
      step("halt_fv", V_FV);
      step("halt_d",  V_D);
      step("halt_s",  V_S);
      step("halt_e",  V_E);
      halt_req = 1'b1;
      start    = 1'b1;
      step("halt_w",  V_W);
      step("halted_retire", V_H_R);
      halt_req = 1'b0;
      start    = 1'b0;
      step("halted_hold1", V_H);
      step("halted_hold2", V_H);
      start = 1'b1;
      step("restart_fetch", V_FR);
      start = 1'b0;

      // 5: asynchronous reset in EXECUTE abandons the instruction
      exec_done = 1'b0;
      step("abort_fv", V_FV);
      step("abort_d",  V_D);
      step("abort_s",  V_S);
      step("abort_e1", V_E);
      step("abort_e2", V_E);
      #2;
      reset_n = 1'b0;
      #1;
      clear_model();
      now("async_reset", V_IDLE);
      check_counters("async_reset");
      step("reset_held_no_retire", V_IDLE);
      @(negedge clk);
      reset_n = 1'b1;
      step("post_reset_idle1", V_IDLE);
      step("post_reset_idle2", V_IDLE);
      start = 1'b1;
      step("post_reset_fetch", V_FR);
      start = 1'b0;

      // 6: 20 back-to-back instructions for counter wrap
      imem_rvalid = 1'b1;
      exec_done   = 1'b1;
      repeat (20) run_fast();
      step("wrap_fv", V_FV);
      check_counters("wrap");
`ifdef SEQ_PERF_COUNT_EN
      n_cmp++;
      assert (instret_count === 4'd4)
      else begin
         n_err++;
         $error("FAIL instret_20_mod_16: observed %0d expected 4", instret_count);
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
